uart_reg_bank: RTL and testbench



---
 rtl/uart_reg_bank_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 79 +++++++
 rtl/uart_reg_bank.sv | 138 +++++++++++++
 tb/tb_uart_reg_bank.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_reg_bank_pkg.sv
// Shared constants for the UART register bank: register addresses and
// bit positions inside LSR, FCR and IER.
package uart_reg_bank_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 16;

    localparam int unsigned REG_RB_TH = 0;
    localparam int unsigned REG_IE    = 1;
    localparam int unsigned REG_FC    = 2;
    localparam int unsigned REG_LS    = 5;
    localparam int unsigned REG_SCR   = 7;

    localparam int unsigned LSR_DR   = 0;
    localparam int unsigned LSR_OE   = 1;
    localparam int unsigned LSR_THRE = 5;
    localparam int unsigned LSR_TEMT = 6;

    localparam int unsigned FCR_RX_CLR = 1;
    localparam int unsigned FCR_TX_CLR = 2;

    localparam int unsigned IER_RDA  = 0;
    localparam int unsigned IER_THRE = 1;
    localparam int unsigned IER_LS   = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with clear-wins semantics, drop-on-full pushes and
// a zeroed head while empty.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == (AW+1)'(DEPTH));
        count     = count_q;
        head      = empty ? '0 : mem_q[rd_ptr_q];
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear && !rst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_reg_bank.sv
// Byte-wide UART register slave: THR/RBR FIFOs, IER, FCR, LSR, SCR and a
// registered interrupt request.
module uart_reg_bank
    import uart_reg_bank_pkg::*;
#(
    parameter int UART_ADDR_WIDTH = 3,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
    parameter int FIFO_AW         = 4
) (
    input  logic                       clk,
    input  logic                       wb_rst_i,
    input  logic                       we_i,
    input  logic                       re_i,
    input  logic [UART_ADDR_WIDTH-1:0] adr_i,
    input  logic [7:0]                 dat_i,
    output logic [7:0]                 dat_o,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       int_o
);

    localparam logic [UART_ADDR_WIDTH-1:0] A_RB  = UART_ADDR_WIDTH'(REG_RB_TH);
    localparam logic [UART_ADDR_WIDTH-1:0] A_IE  = UART_ADDR_WIDTH'(REG_IE);
    localparam logic [UART_ADDR_WIDTH-1:0] A_FC  = UART_ADDR_WIDTH'(REG_FC);
    localparam logic [UART_ADDR_WIDTH-1:0] A_LS  = UART_ADDR_WIDTH'(REG_LS);
    localparam logic [UART_ADDR_WIDTH-1:0] A_SCR = UART_ADDR_WIDTH'(REG_SCR);

    logic [2:0]       ier_q, ier_d;
    logic [7:0]       scr_q, scr_d;
    logic             oe_q, oe_d;
    logic             int_q, int_d;

    logic             tx_push_s, tx_pop_s, tx_clear_s, tx_full_s, tx_empty_s;
    logic             rx_push_s, rx_pop_s, rx_clear_s, rx_full_s, rx_empty_s;
    logic [FIFO_AW:0] tx_count_s, rx_count_s;
    logic [7:0]       rx_head_s, lsr_s;
    logic             thr_wr_s, rbr_rd_s, fcr_wr_s, lsr_rd_s;
    logic             dr_s, thre_s, temt_s, overrun_s;

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .W(8)) u_tx_fifo (
        .clk   (clk),
        .rst   (wb_rst_i),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .clear (tx_clear_s),
        .din   (dat_i),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s),
        .head  (tx_data)
    );

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .W(8)) u_rx_fifo (
        .clk   (clk),
        .rst   (wb_rst_i),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .clear (rx_clear_s),
        .din   (rx_data),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s),
        .head  (rx_head_s)
    );

    // Strobe decode, FIFO handshakes, status flags and read mux.
    always_comb begin
        thr_wr_s   = we_i & (adr_i == A_RB);
        rbr_rd_s   = re_i & (adr_i == A_RB);
        fcr_wr_s   = we_i & (adr_i == A_FC);
        lsr_rd_s   = re_i & (adr_i == A_LS);
        tx_valid   = ~tx_empty_s;
        tx_pop_s   = tx_valid & tx_ready;
        tx_push_s  = thr_wr_s & (~tx_full_s | tx_pop_s);
        tx_clear_s = fcr_wr_s & dat_i[FCR_TX_CLR];
        rx_pop_s   = rbr_rd_s & ~rx_empty_s;
        rx_push_s  = rx_valid & (~rx_full_s | rx_pop_s);
        rx_clear_s = fcr_wr_s & dat_i[FCR_RX_CLR];
        overrun_s  = rx_valid & rx_full_s & ~rx_pop_s;
        dr_s       = (rx_count_s != '0);
        thre_s     = (tx_count_s == '0);
        temt_s     = thre_s & tx_ready;
        lsr_s      = 8'h00;
        lsr_s[LSR_DR]   = dr_s;
        lsr_s[LSR_OE]   = oe_q;
        lsr_s[LSR_THRE] = thre_s;
        lsr_s[LSR_TEMT] = temt_s;
        case (adr_i)
            A_RB:    dat_o = rx_head_s;
            A_IE:    dat_o = {5'b00000, ier_q};
            A_LS:    dat_o = lsr_s;
            A_SCR:   dat_o = scr_q;
            default: dat_o = 8'h00;
        endcase
    end

    // Register writes and the sticky overrun flag; a new overrun beats an LSR read.
    always_comb begin
        if (we_i && (adr_i == A_IE)) begin
            ier_d = dat_i[2:0];
        end else begin
            ier_d = ier_q;
        end
        if (we_i && (adr_i == A_SCR)) begin
            scr_d = dat_i;
        end else begin
            scr_d = scr_q;
        end
        if (overrun_s) begin
            oe_d = 1'b1;
        end else if (lsr_rd_s) begin
            oe_d = 1'b0;
        end else begin
            oe_d = oe_q;
        end
        int_d = (ier_q[IER_RDA] & dr_s) | (ier_q[IER_THRE] & thre_s) | (ier_q[IER_LS] & oe_q);
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            ier_q <= 3'b000;
            scr_q <= 8'h00;
            oe_q  <= 1'b0;
            int_q <= 1'b0;
        end else begin
            ier_q <= ier_d;
            scr_q <= scr_d;
            oe_q  <= oe_d;
            int_q <= int_d;
        end
    end

    assign int_o = int_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed bench for uart_reg_bank: a register-access vector table followed
// by hand-written FIFO, overrun, interrupt and reset sequences.
module tb_uart_reg_bank;

    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       we_i = 1'b0;
    logic       re_i = 1'b0;
    logic [2:0] adr_i = 3'd0;
    logic [7:0] dat_i = 8'h00;
    logic [7:0] dat_o;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       int_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [2:0] adr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [15];

    uart_reg_bank dut (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .we_i     (we_i),
        .re_i     (re_i),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .dat_o    (dat_o),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .int_o    (int_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we_i  = 1'b1;
        adr_i = a;
        dat_i = d;
        tick();
        we_i  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
        re_i  = 1'b1;
        adr_i = a;
        #1;
        check(nm, dat_o, e);
        tick();
        re_i  = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, input logic [7:0] e, input string nm);
        re_i  = 1'b0;
        adr_i = a;
        #1;
        check(nm, dat_o, e);
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        //            we    re    adr   dat    exp
        tbl[0]  = '{1'b0, 1'b1, 3'd1, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h60};
        tbl[2]  = '{1'b0, 1'b1, 3'd7, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 3'd1, 8'hFF, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 3'd1, 8'h00, 8'h07};
        tbl[5]  = '{1'b1, 1'b0, 3'd1, 8'h00, 8'h07};
        tbl[6]  = '{1'b1, 1'b0, 3'd7, 8'h5A, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 3'd7, 8'h00, 8'h5A};
        tbl[8]  = '{1'b0, 1'b1, 3'd2, 8'h00, 8'h00};
        tbl[9]  = '{1'b1, 1'b0, 3'd3, 8'hFF, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 3'd3, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 3'd4, 8'h00, 8'h00};
        tbl[12] = '{1'b0, 1'b1, 3'd6, 8'h00, 8'h00};
        tbl[13] = '{1'b0, 1'b1, 3'd0, 8'h00, 8'h00};
        tbl[14] = '{1'b0, 1'b1, 3'd5, 8'h00, 8'h60};

        tick();
        tick();
        check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_int", {7'd0, int_o}, 8'h00);
        wb_rst_i = 1'b0;

        for (int i = 0; i < 15; i++) begin
            we_i  = tbl[i].we;
            re_i  = tbl[i].re;
            adr_i = tbl[i].adr;
            dat_i = tbl[i].dat;
            #1;
            check($sformatf("vec%0d", i), dat_o, tbl[i].exp);
            tick();
        end
        we_i = 1'b0;
        re_i = 1'b0;
        tick();

        // TX ordering and THRE
        tx_ready = 1'b0;
        wr(3'd0, 8'h41);
        wr(3'd0, 8'h42);
        check("tx_valid_q", {7'd0, tx_valid}, 8'h01);
        check("tx_head_41", tx_data, 8'h41);
        peek(3'd5, 8'h00, "lsr_tx_busy");
        tx_ready = 1'b1;
        #1;
        check("tx_deliver0", tx_data, 8'h41);
        tick();
        check("tx_deliver1", tx_data, 8'h42);
        tick();
        tx_ready = 1'b0;
        check("tx_drained", {7'd0, tx_valid}, 8'h00);
        check("tx_data_empty", tx_data, 8'h00);
        peek(3'd5, 8'h20, "lsr_thre");

        // TX full: 17th byte dropped, then push+pop on full
        for (int i = 0; i < 17; i++) wr(3'd0, 8'h50 + 8'(i));
        check("tx_full_head", tx_data, 8'h50);
        tx_ready = 1'b1;
        wr(3'd0, 8'h70);
        tx_ready = 1'b0;
        check("tx_pushpop_head", tx_data, 8'h51);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_drain%0d", i), tx_data, (i < 15) ? 8'h51 + 8'(i) : 8'h70);
            tick();
        end
        check("tx_full_drained", {7'd0, tx_valid}, 8'h00);
        // push into empty FIFO while ready: no pop that cycle
        wr(3'd0, 8'h77);
        check("tx_empty_push_valid", {7'd0, tx_valid}, 8'h01);
        check("tx_empty_push_data", tx_data, 8'h77);
        tick();
        check("tx_empty_push_gone", {7'd0, tx_valid}, 8'h00);
        tx_ready = 1'b0;

        // RX fill with overrun; keep one byte in TX so THRE/TEMT read 0
        wr(3'd0, 8'h33);
        for (int i = 0; i < 17; i++) rx_push(8'(i));
        peek(3'd5, 8'h03, "lsr_overrun");
        rd(3'd5, 8'h03, "lsr_rd_overrun");
        peek(3'd5, 8'h01, "lsr_oe_cleared");
        for (int i = 0; i < 16; i++) rd(3'd0, 8'(i), $sformatf("rbr%0d", i));
        rd(3'd0, 8'h00, "rbr_underflow");
        peek(3'd5, 8'h00, "lsr_rx_empty");

        // overrun and LSR read in the same cycle: set wins
        for (int i = 0; i < 16; i++) rx_push(8'h20 + 8'(i));
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        re_i     = 1'b1;
        adr_i    = 3'd5;
        #1;
        check("lsr_pre_set", dat_o, 8'h01);
        tick();
        rx_valid = 1'b0;
        re_i     = 1'b0;
        peek(3'd5, 8'h03, "oe_set_wins");
        rd(3'd5, 8'h03, "lsr_rd2");
        peek(3'd5, 8'h01, "lsr_oe_cleared2");

        // full RX: push with same-cycle RBR pop
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        re_i     = 1'b1;
        adr_i    = 3'd0;
        #1;
        check("rbr_old_head", dat_o, 8'h20);
        tick();
        rx_valid = 1'b0;
        re_i     = 1'b0;
        peek(3'd5, 8'h01, "no_oe_on_pushpop");
        for (int i = 0; i < 16; i++) rd(3'd0, (i < 15) ? 8'h21 + 8'(i) : 8'h99, $sformatf("rbr_b%0d", i));
        peek(3'd5, 8'h00, "lsr_rx_empty2");

        // THRE interrupt
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("tx_empty_int", {7'd0, tx_valid}, 8'h00);
        wr(3'd1, 8'h02);
        tick();
        check("int_thre", {7'd0, int_o}, 8'h01);
        wr(3'd0, 8'h44);
        check("int_lag", {7'd0, int_o}, 8'h01);
        tick();
        check("int_thre_off", {7'd0, int_o}, 8'h00);
        wr(3'd2, 8'h04);
        check("fcr_tx_clear", {7'd0, tx_valid}, 8'h00);
        check("int_still_off", {7'd0, int_o}, 8'h00);
        tick();
        check("int_thre_back", {7'd0, int_o}, 8'h01);

        // RX clear wins over same-cycle push
        rx_push(8'h11);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        wr(3'd2, 8'h02);
        rx_valid = 1'b0;
        peek(3'd5, 8'h20, "fcr_rx_clear_wins");

        // data-ready interrupt
        wr(3'd1, 8'h01);
        tick();
        check("int_dr_idle", {7'd0, int_o}, 8'h00);
        rx_push(8'h66);
        tick();
        check("int_dr", {7'd0, int_o}, 8'h01);
        wr(3'd2, 8'h02);
        tick();
        check("int_dr_cleared", {7'd0, int_o}, 8'h00);

        // reset in the middle of a TX burst
        wr(3'd7, 8'hA5);
        rd(3'd7, 8'hA5, "scr_a5");
        wr(3'd0, 8'h01);
        wr(3'd0, 8'h02);
        wr(3'd0, 8'h03);
        tx_ready = 1'b1;
        #1;
        check("burst0", tx_data, 8'h01);
        tick();
        check("burst1", tx_data, 8'h02);
        wb_rst_i = 1'b1;
        tick();
        check("rst_mid_valid", {7'd0, tx_valid}, 8'h00);
        check("rst_mid_data", tx_data, 8'h00);
        check("rst_mid_int", {7'd0, int_o}, 8'h00);
        wb_rst_i = 1'b0;
        rd(3'd7, 8'h00, "scr_after_rst");
        peek(3'd1, 8'h00, "ier_after_rst");
        peek(3'd5, 8'h60, "lsr_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
